// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - WidthSrc codes (word / half / byte)
//   - FSM state encoding
//   - byte-enable size masks and helpers for lane masks and word spanning
package lsu_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b10;
    localparam logic [1:0] WIDTH_BYTE = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BEAT1  = 2'd1,
        BEAT2  = 2'd2,
        FINISH = 2'd3
    } lsu_state_e;

    localparam logic [3:0] MASK_WORD = 4'b1111;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_BYTE = 4'b0001;

    function automatic logic [3:0] size_mask(input logic [1:0] w);
        case (w)
            WIDTH_HALF: size_mask = MASK_HALF;
            WIDTH_BYTE: size_mask = MASK_BYTE;
            default:    size_mask = MASK_WORD;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] w);
        case (w)
            WIDTH_HALF: size_bytes = 3'd2;
            WIDTH_BYTE: size_bytes = 3'd1;
            default:    size_bytes = 3'd4;
        endcase
    endfunction

    // True when the access runs past the end of its word (off + size > 4).
    function automatic logic spans(input logic [1:0] w, input logic [1:0] off);
        spans = ({1'b0, off} + size_bytes(w)) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data assembly.
//   Merges the right-justified beat-1 bytes with the low bytes of the beat-2
//   word (split accesses), then sign- or zero-extends to WIDTH.
// Ports:
//   beat1_data  in  WIDTH  beat-1 word already shifted down by 8*off
//   beat2_data  in  WIDTH  raw beat-2 read word
//   off         in  2      byte offset of the access
//   width       in  2      WidthSrc code
//   is_unsigned in  1      zero-extend when 1
//   split       in  1      beat2_data contributes the upper bytes
//   rdata       out WIDTH  extended load result
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] beat1_data,
    input  logic [WIDTH-1:0] beat2_data,
    input  logic [1:0]       off,
    input  logic [1:0]       width,
    input  logic             is_unsigned,
    input  logic             split,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] merged;

    function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] m,
                                                input logic [1:0]       w,
                                                input logic             uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = m[7:0];
        h = m[15:0];
        case (w)
            WIDTH_BYTE: extend = uns ? {{(WIDTH-8){1'b0}}, m[7:0]}   : WIDTH'(b);
            WIDTH_HALF: extend = uns ? {{(WIDTH-16){1'b0}}, m[15:0]} : WIDTH'(h);
            default:    extend = m;
        endcase
    endfunction

    // Beat-1 supplies (4 - off) low bytes; beat-2 bytes land right above them.
    // off is never 0 when split, so the shift stays below WIDTH.
    always_comb begin
        merged = beat1_data;
        if (split)
            merged = beat1_data | (beat2_data << {(3'd4 - {1'b0, off}), 3'b000});
    end

    assign rdata = extend(merged, width, is_unsigned);

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator towards a word-organised data memory.
//   Accepts one load/store from the core, issues one or two word-aligned
//   beats with byte enables and lane-shifted write data, returns aligned and
//   extended load data, and holds busy until the access completes.
// Configuration macro: MISALIGNED_SPLIT_EN
//   defined   - word-spanning accesses are split into two beats
//   undefined - word-spanning accesses do no beat and pulse misalign_err
// Ports:
//   clk, reset (async, active-high)
//   ls_valid/ls_we/WidthSrc/ls_unsigned/ls_addr/ls_wdata  core request
//   busy/done/ls_rdata/misalign_err                       core response
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata              memory beat
//   mem_rdata/mem_ready                                   memory response
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BE_W  = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ls_valid,
    input  logic             ls_we,
    input  logic [1:0]       WidthSrc,
    input  logic             ls_unsigned,
    input  logic [WIDTH-1:0] ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ls_rdata,
    output logic             misalign_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [BE_W-1:0]  mem_be,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    lsu_state_e       state, state_nxt;
    logic [WIDTH-1:0] addr_q, wdata_q, beat1_q;
    logic [1:0]       width_q;
    logic             we_q, uns_q, err_q;
    logic             accept, last_beat;
    logic [1:0]       off;
    logic [3:0]       be1;
    logic [WIDTH-1:0] beat1_now, beat1_sel, load_word;

    assign off       = addr_q[1:0];
    assign accept    = (state == IDLE) && ls_valid && (WidthSrc != 2'b11);
    assign be1       = size_mask(width_q) << off;
    assign beat1_now = mem_rdata >> {off, 3'b000};

`ifdef MISALIGNED_SPLIT_EN
    logic       span_q;
    logic [3:0] be2;
    assign span_q    = spans(width_q, off);
    // Bytes pushed past lane 3 by the beat-1 shift wrap into the low lanes.
    assign be2       = size_mask(width_q) >> (3'd4 - {1'b0, off});
    assign last_beat = mem_ready && (((state == BEAT1) && !span_q) || (state == BEAT2));
`else
    assign last_beat = mem_ready && (state == BEAT1);
`endif

    // Beat-1 bytes come straight off the bus when this is the final beat.
    assign beat1_sel = (state == BEAT1) ? beat1_now : beat1_q;

    lsu_load_align #(.WIDTH(WIDTH)) u_align (
        .beat1_data  (beat1_sel),
        .beat2_data  (mem_rdata),
        .off         (off),
        .width       (width_q),
        .is_unsigned (uns_q),
        .split       (state == BEAT2),
        .rdata       (load_word)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Control registers and the externally visible load result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q    <= 1'b0;
            ls_rdata <= '0;
        end else begin
            if (accept) begin
`ifdef MISALIGNED_SPLIT_EN
                err_q <= 1'b0;
`else
                err_q <= spans(WidthSrc, ls_addr[1:0]);
`endif
            end
            if (last_beat && !we_q)
                ls_rdata <= load_word;
        end
    end

    // Request payload; only observed while the FSM is out of IDLE
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= ls_addr;
            wdata_q <= ls_wdata;
            width_q <= WidthSrc;
            we_q    <= ls_we;
            uns_q   <= ls_unsigned;
        end
        if ((state == BEAT1) && mem_ready)
            beat1_q <= beat1_now;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MISALIGNED_SPLIT_EN
                    state_nxt = BEAT1;
`else
                    state_nxt = spans(WidthSrc, ls_addr[1:0]) ? FINISH : BEAT1;
`endif
                end
            end
            BEAT1: begin
                if (mem_ready) begin
`ifdef MISALIGNED_SPLIT_EN
                    state_nxt = span_q ? BEAT2 : FINISH;
`else
                    state_nxt = FINISH;
`endif
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            BEAT2:   if (mem_ready) state_nxt = FINISH;
`endif
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy         = (state != IDLE);
        done         = 1'b0;
        misalign_err = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_be       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state)
            BEAT1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_be    = be1;
                mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
                mem_wdata = wdata_q << {off, 3'b000};
            end
`ifdef MISALIGNED_SPLIT_EN
            BEAT2: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_be    = be2;
                mem_addr  = {addr_q[WIDTH-1:2], 2'b00} + WIDTH'(4);
                mem_wdata = wdata_q >> {(3'd4 - {1'b0, off}), 3'b000};
            end
`endif
            FINISH: begin
                done         = !err_q;
                misalign_err = err_q;
            end
            default: ;
        endcase
    end

endmodule
